// File: rtl/mul_product_accumulator_pkg.sv
// Shared definitions for the 4-bit multiplier and its product accumulator.
package mul_product_accumulator_pkg;

  // Multiplier operand width and the resulting product width.
  localparam int unsigned MUL_OP_W       = 4;
  localparam int unsigned DEFAULT_PROD_W = 2 * MUL_OP_W;

  // Accumulator control states.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // ceil(log2(n)); returns 0 for n <= 1.
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_product_accumulator.sv
// Sums batches of COUNT multiplier products and offers each batch sum on a
// valid/ready output; products arriving while a sum waits are dropped and
// flagged.
module mul_product_accumulator
  import mul_product_accumulator_pkg::*;
#(
  parameter  int unsigned PROD_W = DEFAULT_PROD_W,
  parameter  int unsigned COUNT  = 4,
  localparam int unsigned ACC_W  = PROD_W + clog2w(COUNT),
  localparam int unsigned CNT_W  = (clog2w(COUNT + 1) == 0) ? 1 : clog2w(COUNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [CNT_W-1:0]  count_out,
  output logic              dropped
);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] sum_q;
  logic             sum_valid_q;
  logic             dropped_q;

  logic [ACC_W-1:0] acc_d;
  logic             last_d;

  // Running total including the incoming product, and whether it closes the batch.
  always_comb begin
    acc_d  = acc_q + ACC_W'(prod_in);
    last_d = (count_q == CNT_W'(COUNT - 1));
  end

  // Batch FSM: accumulate products, then hold the sum until it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      sum_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            if (last_d) begin
              sum_q       <= acc_d;
              sum_valid_q <= 1'b1;
              acc_q       <= '0;
              count_q     <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q   <= acc_d;
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid_q <= 1'b0;
            state_q     <= ACCUM;
            // A product arriving with the handoff starts the next batch; with
            // single-product batches it is itself the next sum.
            if (prod_valid) begin
              if (COUNT == 1) begin
                sum_q       <= ACC_W'(prod_in);
                sum_valid_q <= 1'b1;
                state_q     <= HOLD;
                acc_q       <= '0;
                count_q     <= '0;
              end else begin
                acc_q   <= ACC_W'(prod_in);
                count_q <= CNT_W'(1);
              end
            end
          end else if (prod_valid) begin
            dropped_q <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign count_out = count_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Randomized and directed checks of mul_product_accumulator against a
// queue-based batch model.
module tb_mul_product_accumulator;
  import mul_product_accumulator_pkg::*;

  localparam int unsigned PW  = 8;
  localparam int unsigned CNT = 4;
  localparam int unsigned AW  = PW + clog2w(CNT);
  localparam int unsigned CW  = clog2w(CNT + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] prod_in;
  logic          prod_valid;
  logic          clear;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic [CW-1:0] count_out;
  logic          dropped;

  mul_product_accumulator #(.PROD_W(PW), .COUNT(CNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .clear      (clear),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .count_out  (count_out),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: products of the open batch, the pending sum, sticky drop.
  int unsigned m_q[$];
  int unsigned m_sum     = 0;
  bit          m_valid   = 1'b0;
  bit          m_dropped = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_accept(input int unsigned p);
    int unsigned s;
    m_q.push_back(p);
    if (m_q.size() == CNT) begin
      s = 0;
      foreach (m_q[i]) s += m_q[i];
      m_sum   = s;
      m_valid = 1'b1;
      m_q.delete();
    end
  endtask

  task automatic model_step(input bit rst, input bit clr, input bit pv,
                            input int unsigned p, input bit rdy);
    if (rst) begin
      m_q.delete();
      m_sum     = 0;
      m_valid   = 1'b0;
      m_dropped = 1'b0;
    end else if (clr) begin
      m_q.delete();
      m_valid   = 1'b0;
      m_dropped = 1'b0;
    end else if (!m_valid) begin
      if (pv) model_accept(p);
    end else if (rdy) begin
      m_valid = 1'b0;
      if (pv) model_accept(p);
    end else if (pv) begin
      m_dropped = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cycle(input bit rst, input bit clr, input bit pv,
                       input int unsigned p, input bit rdy);
    int unsigned pm;
    pm         = p % (1 << PW);
    reset      = rst;
    clear      = clr;
    prod_valid = pv;
    prod_in    = pm[PW-1:0];
    sum_ready  = rdy;
    model_step(rst, clr, pv, pm, rdy);
    @(posedge clk);
    #1;
    check("sum_valid", sum_valid, m_valid);
    check("sum_out",   sum_out,   m_sum);
    check("count_out", count_out, m_q.size());
    check("dropped",   dropped,   m_dropped);
  endtask

  task automatic product(input int unsigned p, input bit rdy);
    cycle(1'b0, 1'b0, 1'b1, p, rdy);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  int unsigned r;

  initial begin
    reset = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_in = '0; sum_ready = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("reset_sum", sum_out, 0);
    check("reset_valid", sum_valid, 0);
    check("reset_count", count_out, 0);
    check("reset_dropped", dropped, 0);

    // Full batch of 15*15 with 1-cycle latency
    for (int i = 0; i < 3; i++) product(225, 1'b1);
    check("full_not_yet", sum_valid, 0);
    product(225, 1'b1);
    check("full_valid", sum_valid, 1);
    check("full_sum", sum_out, 900);
    check("full_count", count_out, 0);
    idle(1'b1);
    check("full_taken", sum_valid, 0);

    // Largest products: sum fits ACC_W exactly
    for (int i = 0; i < 4; i++) product(255, 1'b0);
    check("max_sum", sum_out, 1020);
    idle(1'b1);

    // Backpressure and drop
    product(10, 1'b0); product(20, 1'b0); product(30, 1'b0); product(40, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    product(8'h55, 1'b0);
    check("bp_sum", sum_out, 100);
    check("bp_dropped", dropped, 1);
    idle(1'b1);
    check("bp_released", sum_valid, 0);
    check("bp_count", count_out, 0);
    check("bp_sticky", dropped, 1);

    // Simultaneous handoff and first product of next batch
    product(10, 1'b0); product(20, 1'b0); product(30, 1'b0); product(40, 1'b0);
    check("hs_hold_sum", sum_out, 100);
    product(16, 1'b1);
    check("hs_valid", sum_valid, 0);
    check("hs_count", count_out, 1);
    for (int i = 0; i < 3; i++) product(16, 1'b0);
    check("hs_sum", sum_out, 64);
    idle(1'b1);

    // Clear mid-batch wins over a coincident product
    product(50, 1'b0); product(60, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 99, 1'b0);
    check("clr_count", count_out, 0);
    check("clr_dropped", dropped, 0);
    for (int i = 0; i < 4; i++) product(1, 1'b0);
    check("clr_sum", sum_out, 4);

    // Clear while holding discards the sum
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
    check("clr_hold_valid", sum_valid, 0);

    // Reset in HOLD
    product(5, 1'b0); product(6, 1'b0); product(7, 1'b0); product(8, 1'b0);
    check("rh_valid", sum_valid, 1);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("rh_after_valid", sum_valid, 0);
    check("rh_after_sum", sum_out, 0);
    product(1, 1'b0); product(2, 1'b0); product(3, 1'b0); product(4, 1'b0);
    check("rh_sum", sum_out, 10);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 255);
      cycle(r == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 255), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
